acc_req_arbiter: RTL and testbench
==================================

ACC_REQ_ARBITER -- requirements
Module: acc_req_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 8, the number of requesters sharing one accelerator port (range 2..16).
REQ-002 SHALL have parameter AddrWidth, default 4, the request address width (passed through unchanged).
REQ-003 SHALL have parameter DataWidth, default 32, the operand and result data width.
REQ-004 SHALL have parameter IdWidth, default 1, the requester-side transaction ID width.
REQ-005 SHALL have parameter MaxOutstanding, default 4, the global limit on unanswered requests (range 1..255).
REQ-006 SHALL derive ExtIdWidth = IdWidth + clog2(NumReq); ext_id = {requester index, original id}.
REQ-007 clk_i  in  1  clock; the single clock, all state updates on its rising edge.
REQ-008 rst_ni  in  1  reset; asynchronous, active-low.
REQ-009 mst_q_valid_i  in  NumReq  per-requester request valid.
REQ-010 mst_q_ready_o  out  NumReq  per-requester request ready.
REQ-011 mst_q_addr_i / mst_q_data_i / mst_q_id_i  in  NumReq x (AddrWidth / 3*DataWidth / IdWidth)  request payload.
REQ-012 mst_p_valid_o  out  NumReq  per-requester response valid.
REQ-013 mst_p_ready_i  in  NumReq  per-requester response ready.
REQ-014 mst_p_data_o / mst_p_id_o  out  DataWidth / IdWidth (shared by all requesters)  response payload.
REQ-015 slv_q_valid_o, slv_q_ready_i, slv_q_addr_o, slv_q_data_o, slv_q_id_o (ExtIdWidth)  accelerator-side request port.
REQ-016 slv_p_valid_i, slv_p_ready_o, slv_p_data_i, slv_p_id_i (ExtIdWidth)  accelerator-side response port.
REQ-017 outstanding_o  out  8  current unanswered-request count.
REQ-018 rsp_err_o  out  1  one-cycle pulse on a response whose index field is >= NumReq.

Function
REQ-019 Arbitration SHALL be round-robin: a pointer rr_q selects the highest-priority index; among valid requesters, the first at or above rr_q (wrapping) wins.
REQ-020 After a request handshake (slv_q_valid_o && slv_q_ready_i) from winner w, rr_q SHALL become (w+1) mod NumReq in the next cycle; otherwise rr_q is held.
REQ-021 States: IDLE (no lock) and LOCKED (grant held); IDLE->LOCKED when slv_q_valid_o=1 and slv_q_ready_i=0; LOCKED->IDLE on handshake.
REQ-022 In LOCKED the grant SHALL remain on the locked requester regardless of other requesters (valid/payload stable downstream).
REQ-023 slv_q_valid_o SHALL be 1 iff some requester is granted and outstanding_o < MaxOutstanding, or the state is LOCKED.
REQ-024 slv_q_* payload SHALL be the granted requester's payload combinationally; slv_q_id_o = {grant index, mst_q_id_i[grant]}.
REQ-025 mst_q_ready_o[g] SHALL equal slv_q_ready_i && slv_q_valid_o for the granted g only; zero for all others.
REQ-026 outstanding counter: +1 on request handshake, -1 on upstream response handshake, unchanged when both occur in the same cycle.
REQ-027 At outstanding_o == MaxOutstanding, no new grant SHALL be issued (request valid 0, all ready 0) unless a response handshake occurs in that cycle is NOT considered (no same-cycle bypass).
REQ-028 Response routing SHALL be combinational: idx = slv_p_id_i[ExtIdWidth-1:IdWidth]; mst_p_valid_o[idx] = slv_p_valid_i; mst_p_id_o = slv_p_id_i[IdWidth-1:0]; mst_p_data_o = slv_p_data_i; slv_p_ready_o = mst_p_ready_i[idx].
REQ-029 If idx >= NumReq and slv_p_valid_i=1: no mst_p_valid_o asserted, slv_p_ready_o=1 (response dropped), rsp_err_o=1 that cycle, counter decremented.
REQ-030 Counter SHALL never wrap: a decrement at 0 is ignored and a response at count 0 still routes normally.
REQ-031 Request and response paths SHALL operate concurrently with no coupling other than the counter.

Reset
REQ-032 On rst_ni=0 (asynchronous, any cycle, including mid-LOCKED): state=IDLE, rr_q=0, outstanding_o=0, rsp_err_o=0; all valid/ready outputs driven by state are 0 while reset is asserted.
REQ-033 First arbitration after reset release SHALL start from index 0.

Verification
REQ-034 Requesters 0,2,5 valid continuously, slv_q_ready_i=1, responses returned next cycle -> grant order 0,2,5,0,2,5; slv_q_id_o index fields 0,2,5.
REQ-035 Requester 3 valid, slv_q_ready_i=0 for 4 cycles while requester 1 asserts valid -> grant stays 3, payload stable, mst_q_ready_o=0 for all; handshake on cycle 5 goes to 3; next grant 1.
REQ-036 MaxOutstanding=4, no responses, all requesters valid -> exactly 4 handshakes, then slv_q_valid_o=0 and outstanding_o=4; one response -> outstanding_o=3, next cycle one new grant.
REQ-037 slv_p_id_i={3'd6,1'b1} valid, mst_p_ready_i[6]=0 two cycles then 1 -> only mst_p_valid_o[6]=1, mst_p_id_o=1, slv_p_ready_o follows 0,0,1.
REQ-038 NumReq=5, slv_p_id_i index 7 valid -> slv_p_ready_o=1, rsp_err_o pulses one cycle, no mst_p_valid_o set.
REQ-039 Assert rst_ni=0 in LOCKED with outstanding_o=2 -> outputs 0 immediately; after release, first grant to lowest-indexed valid requester at or above 0.

Source files
------------

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter that funnels NumReq requesters into one accelerator port,
// tagging each request with its requester index so responses can be routed back.
module acc_req_arbiter #(
  parameter  int unsigned NumReq         = 8,
  parameter  int unsigned AddrWidth      = 4,
  parameter  int unsigned DataWidth      = 32,
  parameter  int unsigned IdWidth        = 1,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth       = $clog2(NumReq),
  localparam int unsigned ExtIdWidth     = IdWidth + IdxWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     mst_q_valid_i,
  output logic [NumReq-1:0]                     mst_q_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      mst_q_addr_i,
  input  logic [NumReq-1:0][3*DataWidth-1:0]    mst_q_data_i,
  input  logic [NumReq-1:0][IdWidth-1:0]        mst_q_id_i,
  output logic [NumReq-1:0]                     mst_p_valid_o,
  input  logic [NumReq-1:0]                     mst_p_ready_i,
  output logic [DataWidth-1:0]                  mst_p_data_o,
  output logic [IdWidth-1:0]                    mst_p_id_o,
  output logic                                  slv_q_valid_o,
  input  logic                                  slv_q_ready_i,
  output logic [AddrWidth-1:0]                  slv_q_addr_o,
  output logic [3*DataWidth-1:0]                slv_q_data_o,
  output logic [ExtIdWidth-1:0]                 slv_q_id_o,
  input  logic                                  slv_p_valid_i,
  output logic                                  slv_p_ready_o,
  input  logic [DataWidth-1:0]                  slv_p_data_i,
  input  logic [ExtIdWidth-1:0]                 slv_p_id_i,
  output logic [7:0]                            outstanding_o,
  output logic                                  rsp_err_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] lock_q, lock_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [IdxWidth-1:0] arb_idx, cand_idx, gnt_idx, rsp_idx;
  logic                arb_any, req_hs, rsp_hs, rsp_bad;

  // Rotating priority search starting at rr_q.
  always_comb begin
    arb_any  = 1'b0;
    arb_idx  = '0;
    cand_idx = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand_idx = IdxWidth'((int'(rr_q) + i) % int'(NumReq));
      if (!arb_any && mst_q_valid_i[cand_idx]) begin
        arb_any = 1'b1;
        arb_idx = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_idx       = (state_q == StLocked) ? lock_q : arb_idx;
    slv_q_valid_o = rst_ni && ((state_q == StLocked) ||
                               (arb_any && (cnt_q < 8'(MaxOutstanding))));
    slv_q_addr_o  = mst_q_addr_i[gnt_idx];
    slv_q_data_o  = mst_q_data_i[gnt_idx];
    slv_q_id_o    = {gnt_idx, mst_q_id_i[gnt_idx]};
    req_hs        = slv_q_valid_o && slv_q_ready_i;
    mst_q_ready_o = '0;
    mst_q_ready_o[gnt_idx] = req_hs;
  end

  // A stalled offer stays pinned so the accelerator sees a stable request.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    if (req_hs) begin
      state_d = StIdle;
      rr_d    = (gnt_idx == IdxWidth'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (slv_q_valid_o) begin
      state_d = StLocked;
      lock_d  = gnt_idx;
    end
  end

  always_comb begin
    rsp_idx       = slv_p_id_i[ExtIdWidth-1:IdWidth];
    rsp_bad       = int'(rsp_idx) >= int'(NumReq);
    mst_p_data_o  = slv_p_data_i;
    mst_p_id_o    = slv_p_id_i[IdWidth-1:0];
    mst_p_valid_o = '0;
    slv_p_ready_o = 1'b1;
    if (!rsp_bad) begin
      mst_p_valid_o[rsp_idx] = slv_p_valid_i;
      slv_p_ready_o          = mst_p_ready_i[rsp_idx];
    end
    rsp_hs    = slv_p_valid_i && slv_p_ready_o;
    rsp_err_o = rst_ni && slv_p_valid_i && rsp_bad;
  end

  // Saturating at zero: a stray response must not wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (req_hs && !rsp_hs) begin
      cnt_d = cnt_q + 8'd1;
    end else if (!req_hs && rsp_hs && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: default 8-requester instance plus a
// 5-requester instance for out-of-range response indices.
module tb_acc_req_arbiter;

  localparam int N  = 8;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int XW = 4;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]            mst_q_valid, mst_q_ready, mst_p_valid, mst_p_ready;
  logic [N-1:0][AW-1:0]    mst_q_addr;
  logic [N-1:0][3*DW-1:0]  mst_q_data;
  logic [N-1:0][IW-1:0]    mst_q_id;
  logic [DW-1:0]           mst_p_data, slv_p_data;
  logic [IW-1:0]           mst_p_id;
  logic                    slv_q_valid, slv_q_ready, slv_p_valid, slv_p_ready, rsp_err;
  logic [AW-1:0]           slv_q_addr;
  logic [3*DW-1:0]         slv_q_data;
  logic [XW-1:0]           slv_q_id, slv_p_id;
  logic [7:0]              outstanding;

  logic [N5-1:0]           v5_q_valid, v5_q_ready, v5_p_valid, v5_p_ready;
  logic [N5-1:0][AW-1:0]   v5_q_addr;
  logic [N5-1:0][3*DW-1:0] v5_q_data;
  logic [N5-1:0][IW-1:0]   v5_q_id;
  logic [DW-1:0]           v5_p_data, v5_sp_data;
  logic [IW-1:0]           v5_p_id;
  logic                    v5_sq_valid, v5_sq_ready, v5_sp_valid, v5_sp_ready, v5_err;
  logic [AW-1:0]           v5_sq_addr;
  logic [3*DW-1:0]         v5_sq_data;
  logic [XW-1:0]           v5_sq_id, v5_sp_id;
  logic [7:0]              v5_out;

  int total = 0;
  int bad   = 0;

  acc_req_arbiter u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_q_valid_i(mst_q_valid), .mst_q_ready_o(mst_q_ready),
    .mst_q_addr_i(mst_q_addr), .mst_q_data_i(mst_q_data), .mst_q_id_i(mst_q_id),
    .mst_p_valid_o(mst_p_valid), .mst_p_ready_i(mst_p_ready),
    .mst_p_data_o(mst_p_data), .mst_p_id_o(mst_p_id),
    .slv_q_valid_o(slv_q_valid), .slv_q_ready_i(slv_q_ready),
    .slv_q_addr_o(slv_q_addr), .slv_q_data_o(slv_q_data), .slv_q_id_o(slv_q_id),
    .slv_p_valid_i(slv_p_valid), .slv_p_ready_o(slv_p_ready),
    .slv_p_data_i(slv_p_data), .slv_p_id_i(slv_p_id),
    .outstanding_o(outstanding), .rsp_err_o(rsp_err)
  );

  acc_req_arbiter #(.NumReq(N5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_q_valid_i(v5_q_valid), .mst_q_ready_o(v5_q_ready),
    .mst_q_addr_i(v5_q_addr), .mst_q_data_i(v5_q_data), .mst_q_id_i(v5_q_id),
    .mst_p_valid_o(v5_p_valid), .mst_p_ready_i(v5_p_ready),
    .mst_p_data_o(v5_p_data), .mst_p_id_o(v5_p_id),
    .slv_q_valid_o(v5_sq_valid), .slv_q_ready_i(v5_sq_ready),
    .slv_q_addr_o(v5_sq_addr), .slv_q_data_o(v5_sq_data), .slv_q_id_o(v5_sq_id),
    .slv_p_valid_i(v5_sp_valid), .slv_p_ready_o(v5_sp_ready),
    .slv_p_data_i(v5_sp_data), .slv_p_id_i(v5_sp_id),
    .outstanding_o(v5_out), .rsp_err_o(v5_err)
  );

  task automatic clear_inputs();
    mst_q_valid = '0; mst_p_ready = '0; slv_q_ready = 1'b0;
    slv_p_valid = 1'b0; slv_p_id = '0; slv_p_data = '0;
    v5_q_valid = '0; v5_p_ready = '0; v5_sq_ready = 1'b0;
    v5_sp_valid = 1'b0; v5_sp_id = '0; v5_sp_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mst_q_valid = '1;
    slv_q_ready = 1'b1;
    #1;
    total++; if (slv_q_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", slv_q_valid); end
    total++; if (mst_q_ready !== 8'h00) begin bad++; $display("FAIL rst_ready got=%h want=00", mst_q_ready); end
    total++; if (outstanding !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", outstanding); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", rsp_err); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mst_q_valid = '0;
    slv_q_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_idx [6] = '{0, 2, 5, 0, 2, 5};
    int prev = 0;
    mst_p_ready = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mst_q_valid = 8'b0010_0101;
      slv_q_ready = 1'b1;
      slv_p_valid = (k > 0);
      slv_p_id    = {3'(prev), 1'b0};
      #1;
      total++; if (slv_q_id[3:1] !== 3'(exp_idx[k])) begin bad++; $display("FAIL rr_idx[%0d] got=%0d want=%0d", k, slv_q_id[3:1], exp_idx[k]); end
      total++; if (mst_q_ready !== 8'(1 << exp_idx[k])) begin bad++; $display("FAIL rr_ready[%0d] got=%h want=%h", k, mst_q_ready, 8'(1 << exp_idx[k])); end
      total++; if (slv_q_addr !== 4'(exp_idx[k] + 1) || slv_q_data !== {3{32'h1000_0000 + 32'(exp_idx[k])}} || slv_q_id[0] !== 1'(exp_idx[k] & 1)) begin
        bad++; $display("FAIL rr_payload[%0d] got addr=%h id=%h want addr=%h", k, slv_q_addr, slv_q_id, 4'(exp_idx[k] + 1)); end
      if (k > 0) begin
        total++; if (mst_p_valid !== 8'(1 << prev) || slv_p_ready !== 1'b1) begin bad++; $display("FAIL rr_rsp[%0d] got=%h want=%h", k, mst_p_valid, 8'(1 << prev)); end
      end
      total++; if (outstanding !== 8'(k > 0 ? 1 : 0)) begin bad++; $display("FAIL rr_cnt[%0d] got=%0d want=%0d", k, outstanding, (k > 0 ? 1 : 0)); end
      prev = exp_idx[k];
    end
    @(negedge clk);
    mst_q_valid = '0;
    slv_p_valid = 1'b1;
    slv_p_id    = {3'(prev), 1'b0};
    @(negedge clk);
    slv_p_valid = 1'b0;
    #1;
    total++; if (outstanding !== 8'd0) begin bad++; $display("FAIL rr_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_lock_and_async_reset();
    @(negedge clk);
    mst_q_valid = 8'h08;
    slv_q_ready = 1'b0;
    #1;
    total++; if (slv_q_valid !== 1'b1 || slv_q_id[3:1] !== 3'd3 || mst_q_ready !== 8'h00) begin
      bad++; $display("FAIL lock_first got v=%b idx=%0d rdy=%h want v=1 idx=3 rdy=00", slv_q_valid, slv_q_id[3:1], mst_q_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mst_q_valid   = 8'h0A;
      mst_q_addr[1] = 4'(k + 9);
      #1;
      total++; if (slv_q_id[3:1] !== 3'd3 || slv_q_addr !== 4'd4 || mst_q_ready !== 8'h00 || slv_q_valid !== 1'b1) begin
        bad++; $display("FAIL lock_hold[%0d] got idx=%0d addr=%h rdy=%h want idx=3 addr=4 rdy=00", k, slv_q_id[3:1], slv_q_addr, mst_q_ready); end
    end
    @(negedge clk);
    slv_q_ready = 1'b1;
    #1;
    total++; if (mst_q_ready !== 8'h08) begin bad++; $display("FAIL lock_release got=%h want=08", mst_q_ready); end
    @(negedge clk);
    mst_q_valid = 8'h02;
    mst_q_addr[1] = 4'd2;
    #1;
    total++; if (slv_q_id[3:1] !== 3'd1 || mst_q_ready !== 8'h02) begin bad++; $display("FAIL lock_next got idx=%0d rdy=%h want idx=1 rdy=02", slv_q_id[3:1], mst_q_ready); end
    @(negedge clk);
    mst_q_valid = 8'h10;
    slv_q_ready = 1'b0;
    #1;
    total++; if (slv_q_id[3:1] !== 3'd4 || outstanding !== 8'd2) begin bad++; $display("FAIL lock2 got idx=%0d cnt=%0d want idx=4 cnt=2", slv_q_id[3:1], outstanding); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (slv_q_valid !== 1'b0 || mst_q_ready !== 8'h00 || outstanding !== 8'd0) begin
      bad++; $display("FAIL async_rst got v=%b rdy=%h cnt=%0d want 0/00/0", slv_q_valid, mst_q_ready, outstanding); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mst_q_valid = 8'h50;
    slv_q_ready = 1'b1;
    #1;
    total++; if (slv_q_id[3:1] !== 3'd4 || mst_q_ready !== 8'h10) begin bad++; $display("FAIL post_rst got idx=%0d rdy=%h want idx=4 rdy=10", slv_q_id[3:1], mst_q_ready); end
  endtask

  task automatic test_max_outstanding();
    apply_reset();
    mst_q_valid = '1;
    slv_q_ready = 1'b1;
    mst_p_ready = '1;
    #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (slv_q_valid !== 1'b1 || slv_q_id[3:1] !== 3'(k)) begin bad++; $display("FAIL max_gnt[%0d] got v=%b idx=%0d want v=1 idx=%0d", k, slv_q_valid, slv_q_id[3:1], k); end
      @(negedge clk);
      #1;
    end
    total++; if (slv_q_valid !== 1'b0 || mst_q_ready !== 8'h00 || outstanding !== 8'd4) begin
      bad++; $display("FAIL max_full got v=%b rdy=%h cnt=%0d want 0/00/4", slv_q_valid, mst_q_ready, outstanding); end
    slv_p_valid = 1'b1;
    slv_p_id    = 4'b0000;
    #1;
    total++; if (slv_q_valid !== 1'b0 || mst_q_ready !== 8'h00) begin bad++; $display("FAIL max_bypass got v=%b rdy=%h want 0/00", slv_q_valid, mst_q_ready); end
    @(negedge clk);
    slv_p_valid = 1'b0;
    #1;
    total++; if (outstanding !== 8'd3 || slv_q_valid !== 1'b1 || slv_q_id[3:1] !== 3'd4) begin
      bad++; $display("FAIL max_regrant got cnt=%0d v=%b idx=%0d want 3/1/4", outstanding, slv_q_valid, slv_q_id[3:1]); end
    @(negedge clk);
    #1;
    total++; if (outstanding !== 8'd4 || slv_q_valid !== 1'b0) begin bad++; $display("FAIL max_refull got cnt=%0d v=%b want 4/0", outstanding, slv_q_valid); end
  endtask

  task automatic test_rsp_route();
    logic exp_rdy [3] = '{1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      slv_p_valid = 1'b1;
      slv_p_id    = {3'd6, 1'b1};
      slv_p_data  = 32'hCAFE_F00D;
      mst_p_ready = (k < 2) ? 8'hBF : 8'hFF;
      #1;
      total++; if (mst_p_valid !== 8'h40 || mst_p_id !== 1'b1 || mst_p_data !== 32'hCAFE_F00D) begin
        bad++; $display("FAIL route[%0d] got v=%h id=%b d=%h want 40/1/cafef00d", k, mst_p_valid, mst_p_id, mst_p_data); end
      total++; if (slv_p_ready !== exp_rdy[k] || rsp_err !== 1'b0) begin bad++; $display("FAIL route_rdy[%0d] got=%b err=%b want=%b err=0", k, slv_p_ready, rsp_err, exp_rdy[k]); end
      @(negedge clk);
    end
    slv_p_valid = 1'b0;
    #1;
    total++; if (outstanding !== 8'd0) begin bad++; $display("FAIL route_nowrap got=%0d want=0", outstanding); end
  endtask

  task automatic test_bad_index();
    apply_reset();
    v5_q_valid  = 5'b00001;
    v5_sq_ready = 1'b1;
    #1;
    total++; if (v5_sq_valid !== 1'b1 || v5_q_ready !== 5'b00001) begin bad++; $display("FAIL bad_req got v=%b rdy=%b want 1/00001", v5_sq_valid, v5_q_ready); end
    @(negedge clk);
    v5_q_valid  = '0;
    v5_sp_valid = 1'b1;
    v5_sp_id    = {3'd7, 1'b0};
    v5_p_ready  = '0;
    #1;
    total++; if (v5_out !== 8'd1) begin bad++; $display("FAIL bad_cnt1 got=%0d want=1", v5_out); end
    total++; if (v5_sp_ready !== 1'b1 || v5_err !== 1'b1 || v5_p_valid !== 5'b0) begin
      bad++; $display("FAIL bad_drop got rdy=%b err=%b pv=%b want 1/1/00000", v5_sp_ready, v5_err, v5_p_valid); end
    @(negedge clk);
    v5_sp_valid = 1'b0;
    #1;
    total++; if (v5_err !== 1'b0 || v5_out !== 8'd0) begin bad++; $display("FAIL bad_after got err=%b cnt=%0d want 0/0", v5_err, v5_out); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mst_q_addr[i] = 4'(i + 1);
      mst_q_data[i] = {3{32'h1000_0000 + 32'(i)}};
      mst_q_id[i]   = 1'(i & 1);
    end
    for (int i = 0; i < N5; i++) begin
      v5_q_addr[i] = 4'(i);
      v5_q_data[i] = 96'(i);
      v5_q_id[i]   = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_lock_and_async_reset();
    test_max_outstanding();
    test_rsp_route();
    test_bad_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
